// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//
// SPI initiator, mode 0 (SCK idle low, receiver samples MOSI on the SCK rising
// edge), MSB first, SSEL active low. One byte per frame; frames are separated
// by at least GAP_CYC clk cycles of SSEL high. Every pin output is a flop, so
// there is no combinational path from any input to SCK/SSEL/MOSI.
//
// Parameters:
//   CLK_DIV  SCK half-period in clk cycles (2..255)
//   GAP_CYC  minimum SSEL-high time between frames in clk cycles (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset (release is synchronised inside)
//   tx_data   byte to send, sampled on the accept cycle
//   tx_valid  producer has a byte
//   tx_ready  block can accept a byte this cycle (IDLE only)
//   busy      frame in progress (SSEL low or inter-frame gap running)
//   done      one-cycle pulse when a frame completes
//   SCK       SPI clock, idle low
//   SSEL      SPI select, active low, idle high
//   MOSI      SPI data out
//
// Optional build macro SPI_MASTER_MISO_EN adds:
//   MISO      SPI data in (synchronised by two flops)
//   rx_data   byte captured during the last completed frame
//   rx_valid  one-cycle pulse with done when rx_data updates
// -----------------------------------------------------------------------------
module spi_master_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI
`ifdef SPI_MASTER_MISO_EN
  ,
  input  logic       MISO,
  output logic [7:0] rx_data,
  output logic       rx_valid
`endif
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_tx: CLK_DIV must be in 2..255");
  end
  if (GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_gap_cyc
    $error("spi_master_tx: GAP_CYC must be in 1..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  // NOTE: reset asserts asynchronously but releases two clk edges after
  // rst_n rises, so no flop sees reset removal close to an active edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t     state, state_nxt;
  logic [7:0] div_q, div_nxt;
  logic [2:0] bit_q, bit_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic       frame_nxt;
  logic       tick;
  logic       accept;

  // The gap state reuses the divider with its own terminal count.
  assign tick   = (state == S_GAP) ? (div_q == GAP_LAST) : (div_q == DIV_LAST);
  assign accept = tx_valid && tx_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SETUP;
          shift_nxt = tx_data;
          bit_nxt   = 3'd7;
        end
      end
      S_SETUP: if (tick) state_nxt = S_HIGH;
      S_HIGH: begin
        if (tick) begin
          if (bit_q == 3'd0) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_LOW;
            shift_nxt = {shift_q[6:0], 1'b0};
            bit_nxt   = bit_q - 3'd1;
          end
        end
      end
      S_LOW:  if (tick) state_nxt = S_HIGH;
      S_HOLD: if (tick) state_nxt = S_GAP;
      S_GAP:  if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Divider restarts from zero on every state change and stays parked in IDLE.
    div_nxt   = (state_nxt != state || state == S_IDLE) ? 8'd0 : div_q + 8'd1;
    frame_nxt = (state_nxt == S_SETUP) || (state_nxt == S_HIGH) ||
                (state_nxt == S_LOW)   || (state_nxt == S_HOLD);
  end

  // Outputs are registered from the next-state values so each pin changes on
  // the same edge as the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= S_IDLE;
      div_q    <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      SCK      <= 1'b0;
      SSEL     <= 1'b1;
      MOSI     <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_q    <= div_nxt;
      bit_q    <= bit_nxt;
      shift_q  <= shift_nxt;
      SCK      <= (state_nxt == S_HIGH);
      SSEL     <= !frame_nxt;
      MOSI     <= frame_nxt && shift_nxt[7];
      tx_ready <= (state_nxt == S_IDLE);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state == S_GAP) && tick;
    end
  end

`ifdef SPI_MASTER_MISO_EN
  logic [1:0] miso_sync;
  logic [7:0] rx_shift;

  // MISO is sampled on the last cycle of SCK high, long after the
  // synchroniser has settled on the value the receiver drove after SCK fell.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      miso_sync <= 2'b00;
      rx_shift  <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
    end else begin
      miso_sync <= {miso_sync[0], MISO};
      rx_valid  <= 1'b0;
      if (state == S_IDLE && accept) begin
        rx_shift <= 8'd0;
      end else if (state == S_HIGH && tick) begin
        rx_shift <= {rx_shift[6:0], miso_sync[1]};
      end
      if (state == S_GAP && tick) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
//
// Two instances of spi_master_tx share clk/rst_n: dut_a with default
// parameters (CLK_DIV=4, GAP_CYC=4) and dut_b with CLK_DIV=2, GAP_CYC=1.
// A behavioural oversampling SPI receiver watches each instance's pins,
// measures SCK phase lengths, MOSI setup and SSEL gaps, and reassembles bytes.
// Frame latency is predicted from 1 + 17*CLK_DIV + GAP_CYC.
// With SPI_MASTER_MISO_EN defined a slave model shifts a byte out on MISO.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data [2];
  logic [1:0] tx_valid;
  wire  [1:0] tx_ready, busy, done, sck, ssel, mosi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int gapc(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int frame_lat(input int i);
    return 1 + 17 * cdiv(i) + gapc(i);
  endfunction

`ifdef SPI_MASTER_MISO_EN
  logic [7:0] slave_byte = 8'hC3;
  logic [7:0] slave_sh   = 8'h00;
  wire        miso0 = slave_sh[7];
  wire  [7:0] rx_data0, rx_data1;
  wire        rx_valid0, rx_valid1;

  // Mode-0 slave: first bit presented when SSEL falls, next bit after each SCK fall.
  always @(negedge ssel[0]) slave_sh = slave_byte;
  always @(negedge sck[0]) if (!ssel[0]) slave_sh = {slave_sh[6:0], 1'b0};
`endif

  spi_master_tx dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .busy(busy[0]), .done(done[0]),
    .SCK(sck[0]), .SSEL(ssel[0]), .MOSI(mosi[0])
`ifdef SPI_MASTER_MISO_EN
    , .MISO(miso0), .rx_data(rx_data0), .rx_valid(rx_valid0)
`endif
  );

  spi_master_tx #(.CLK_DIV(2), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1]),
    .SCK(sck[1]), .SSEL(ssel[1]), .MOSI(mosi[1])
`ifdef SPI_MASTER_MISO_EN
    , .MISO(1'b0), .rx_data(rx_data1), .rx_valid(rx_valid1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- oversampling receiver / pin monitor ----------------
  int         hi_run   [2] = '{default: 0};
  int         lo_run   [2] = '{default: 0};
  int         gap_run  [2] = '{default: 0};
  int         mosi_age [2] = '{default: 0};
  int         bit_cnt  [2] = '{default: 0};
  int         done_cnt [2] = '{default: 0};
  logic [7:0] rx_sh    [2] = '{default: 8'h00};
  logic [1:0] p_sck  = 2'b00;
  logic [1:0] p_ssel = 2'b11;
  logic [1:0] p_mosi = 2'b00;
  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];
  int         gap_q[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mosi_age[i] = (mosi[i] === p_mosi[i]) ? mosi_age[i] + 1 : 0;
      if (done[i]) done_cnt[i]++;
      if (!ssel[i] && sck[i] && !p_sck[i]) begin
        check($sformatf("sck_low_len_%0d", i), lo_run[i], cdiv(i));
        check($sformatf("mosi_setup_%0d", i), mosi_age[i] >= cdiv(i), 1);
        rx_sh[i] = {rx_sh[i][6:0], mosi[i]};
        bit_cnt[i]++;
      end
      if (rst_n && p_sck[i] && !sck[i])
        check($sformatf("sck_high_len_%0d", i), hi_run[i], cdiv(i));
      if (ssel[i] && !p_ssel[i]) begin
        if (bit_cnt[i] == 8) begin
          if (i == 0) rx_q0.push_back(rx_sh[i]);
          else        rx_q1.push_back(rx_sh[i]);
        end
        bit_cnt[i] = 0;
      end
      if (i == 0 && !ssel[i] && p_ssel[i]) gap_q.push_back(gap_run[i]);
      hi_run[i]  = sck[i] ? hi_run[i] + 1 : 0;
      lo_run[i]  = (!sck[i] && !ssel[i]) ? lo_run[i] + 1 : 0;
      gap_run[i] = ssel[i] ? gap_run[i] + 1 : 0;
      p_sck[i]   = sck[i];
      p_ssel[i]  = ssel[i];
      p_mosi[i]  = mosi[i];
    end
  end

  task automatic check_rx(input int i, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (i == 0 && rx_q0.size() > 0) got = rx_q0.pop_front();
    if (i == 1 && rx_q1.size() > 0) got = rx_q1.pop_front();
    check($sformatf("rx_byte_%0d", i), got, exp);
  endtask

  // Send one byte and check handshake, latency and the byte the receiver saw.
  task automatic send(input int i, input logic [7:0] b);
    int   n;
    logic rxv;
    logic [7:0] rxd;
    rxv = 1'b0;
    rxd = 8'h00;
    @(negedge clk);
    check($sformatf("ready_before_%0d", i), tx_ready[i], 1);
    tx_data[i]  = b;
    tx_valid[i] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("ssel_fall_%0d", i), ssel[i], 0);
    check($sformatf("ready_drop_%0d", i), tx_ready[i], 0);
    check($sformatf("busy_%0d", i), busy[i], 1);
    @(negedge clk);
    tx_valid[i] = 1'b0;
    tx_data[i]  = 8'($urandom);
    n = 1;
    while (!done[i] && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("done_latency_%0d", i), n, frame_lat(i));
    check($sformatf("ready_at_done_%0d", i), tx_ready[i], 1);
    check($sformatf("idle_at_done_%0d", i), {busy[i], ssel[i], sck[i]}, 3'b010);
`ifdef SPI_MASTER_MISO_EN
    rxv = (i == 0) ? rx_valid0 : rx_valid1;
    rxd = (i == 0) ? rx_data0  : rx_data1;
    check($sformatf("rx_valid_at_done_%0d", i), rxv, 1);
    check($sformatf("rx_data_%0d", i), rxd, (i == 0) ? slave_byte : 8'h00);
`endif
    @(negedge clk);
    check_rx(i, b);
  endtask

  logic [7:0] b2b_list [3] = '{8'h00, 8'hFF, 8'h3C};
  int         acc_cyc  [3];

  initial begin
    int n;
    int g;
    int done_before;
    tx_valid   = 2'b00;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;

    // Reset and idle behaviour
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_pins_%0d", i),
            {sck[i], ssel[i], mosi[i], tx_ready[i], busy[i], done[i]}, 6'b010100);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("idle_pins_%0d", i),
              {sck[i], ssel[i], mosi[i], tx_ready[i], busy[i], done[i]}, 6'b010100);
    end
    check("idle_no_done", done_cnt[0] + done_cnt[1], 0);

    // Directed frames
    send(0, 8'hA5);
    send(1, 8'h81);

    // Back-to-back frames with tx_valid held high
    gap_q.delete();
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = b2b_list[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!tx_ready[0] && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", tx_ready[0], 1);
      @(posedge clk); #1;
      acc_cyc[k] = cyc;
      @(negedge clk);
      if (k < 2) tx_data[0] = b2b_list[k + 1];
      else       tx_valid[0] = 1'b0;
    end
    n = 0;
    while (!tx_ready[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    for (int k = 1; k < 3; k++)
      check("b2b_accept_spacing", acc_cyc[k] - acc_cyc[k - 1], frame_lat(0));
    check("b2b_gap_count", gap_q.size(), 3);
    for (int k = 1; k < 3; k++) begin
      g = (gap_q.size() > k) ? gap_q[k] : -1;
      check("b2b_ssel_high", g, gapc(0) + 1);
    end
    for (int k = 0; k < 3; k++) check_rx(0, b2b_list[k]);

    // Randomised frames on both instances
    for (int r = 0; r < 4; r++) begin
`ifdef SPI_MASTER_MISO_EN
      slave_byte = 8'($urandom);
`endif
      send(0, 8'($urandom));
      send(1, 8'($urandom));
    end

`ifdef SPI_MASTER_MISO_EN
    slave_byte = 8'hC3;
    send(0, 8'h55);
`endif

    // Reset in the middle of a frame
    done_before = done_cnt[0];
    @(negedge clk);
    tx_data[0]  = 8'hF0;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    n = 0;
    while (bit_cnt[0] < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("midframe_reached_edge3", bit_cnt[0], 3);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_pins", {sck[0], ssel[0], mosi[0], tx_ready[0], busy[0], done[0]},
          6'b010100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("midframe_no_done", done_cnt[0], done_before);
    check("midframe_no_byte", rx_q0.size(), 0);
`ifdef SPI_MASTER_MISO_EN
    slave_byte = 8'h6E;
`endif
    send(0, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
